gold_scrambler: RTL and testbench
=================================

// Module: gold_scrambler
// PURPOSE
//  Parametrised CCSDS (131.2-B, App. C) Gold-sequence scrambler generator, successor to the fixed
//  code-0, 1-symbol/cycle generator. Runtime-selectable code number n, LANES symbols per cycle,
//  frame-synchronous sequence restart and valid/ready flow control on both sides.
//  Sits between the symbol framer (supplies i_valid/i_sof per symbol group) and the modulator mapper.
// PARAMETERS
//  LANES     1      symbols per beat (1,2,4,8); lane k carries sequence index i+k
//  FRAME_LEN 16384  symbols per frame; after FRAME_LEN symbols, sequence restarts at seed state
//                   (multiple of LANES, >= LANES)
// PORTS
//  i_clk        in   1        clock
//  i_reset      in   1        reset
//  i_code_load  in   1        pulse: latch i_code_n and re-seed
//  i_code_n     in   18       Gold code number n, 0..2^18-2
//  o_busy       out  1        seed advance in progress
//  i_valid      in   1        upstream beat request
//  i_sof        in   1        with i_valid: beat is first of frame
//  o_ready      out  1        beat accepted when i_valid & o_ready
//  o_valid      out  1        output beat valid
//  o_sof        out  1        output beat is first of frame
//  o_r          out  2*LANES  o_r[2k+1:2k] = R_n(i+k) = {z_n(i+k+131072), z_n(i+k)}
//  i_ready      in   1        downstream accepts output beat
// BEHAVIOUR
//  - Reset: i_reset asynchronous, active-high; clock i_clk. x=18'h00001, y=18'h3FFFF,
//    x_seed=18'h00001, code=0, state RUN, sym_cnt=0, o_valid=0, o_sof=0, o_r=0, o_busy=0.
//  - Recursions per step: x <= {x[7]^x[0], x[17:1]}; y <= {y[10]^y[7]^y[5]^y[0], y[17:1]}.
//    z(i)=x[0]^y[0]; z(i+131072)=(x[4]^x[6]^x[15])^(y[5]^y[6]^y[8]^..^y[15]).
//    Lane k uses the state advanced k steps (unrolled combinationally). Per beat: advance LANES steps.
//  - FSM RUN/SEED. i_code_load in RUN with o_busy=0: latch n; x<=1, y<=all-ones; cnt<=n;
//    if n==0 stay RUN, else SEED. SEED: advance x only, one step/cycle, cnt--. At cnt==1 the
//    last step is taken: x_seed<=advanced x, ->RUN. o_busy=1 exactly n cycles.
//    i_code_load while SEED ignored. Any held output beat is kept until consumed.
//  - o_ready = (state==RUN) & ~i_code_load & (~o_valid | i_ready). i_code_load and i_valid in
//    the same cycle: load wins, beat not accepted.
//  - Accepted beat: if i_sof or sym_cnt==0, generate from (x_seed, all-ones) and o_sof=1;
//    else generate from current (x,y) and o_sof=0. Then x/y <= state advanced LANES steps.
//    sym_cnt += LANES, wraps to 0 at FRAME_LEN (auto restart even without i_sof).
//    i_sof mid-frame forces restart and sym_cnt<=LANES.
//  - Latency 1: o_r/o_sof registered, o_valid set the cycle after acceptance. Held stable while
//    o_valid & ~i_ready. o_valid cleared on i_ready with no new accept.
//  - Sequence index wrap mod 2^18-1 is inherent in the LFSR. No explicit handling.
//  - i_code_n >= 2^18-1: behaviour is advance-count literal (aliases mod 2^18-1). Not flagged.
// STRUCTURE
//  - Package gold_scrambler_pkg: X_SEED, Y_SEED, X/Y feedback taps, Z_HI tap masks,
//    function step_xy(x,y), function z_pair(x,y) -> 2 bits, enum state_t {RUN, SEED}.
//  - Sub-module gold_lfsr_unroll #(STEPS): combinational, emits STEPS z_pairs plus the state
//    advanced STEPS steps. Instantiated once with STEPS=LANES.
// TESTING (bit-exact against a C/Python model of App. C for every scenario)
//  1 Reset, LANES=1, n=0, i_sof beat -> o_valid next cycle, o_sof=1, o_r=2'b00.
//    Stream 1000 symbols matches model.
//  2 i_code_load n=1 -> o_busy high exactly 1 cycle. First beat o_r=2'b01.
//    Load n=5 -> o_busy exactly 5 cycles, o_ready=0 throughout.
//  3 LANES=4, FRAME_LEN=8: 3 beats, no i_sof -> beat 2 has o_sof=1 and o_r == beat 0.
//    i_sof on beat 1 also restarts.
//  4 Backpressure: i_ready=0 for 3 cycles with i_valid=1 -> o_r/o_sof stable, o_ready=0,
//    no symbol skipped or duplicated after release.
//  5 Simultaneous i_code_load and i_valid -> beat not accepted. Load during SEED ignored.
//  6 i_reset asserted mid-SEED (n=1000 at cycle 10) -> immediate x=1, o_busy=0, o_valid=0.
//    Next frame equals code-0 sequence.

Source files
------------

// File: rtl/gold_scrambler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gold_scrambler_pkg
//  Purpose  : Shared constants, types and single-step helpers for the CCSDS
//             Gold-sequence scrambler (x/y LFSR pair, z-pair extraction).
//  Revision : 1.0  initial multi-lane, runtime-code release
// ============================================================================
package gold_scrambler_pkg;

  // Starting states for both LFSRs (x is re-advanced by n for code n)
  localparam logic [17:0] X_SEED = 18'h00001;
  localparam logic [17:0] Y_SEED = 18'h3FFFF;

  // Feedback taps: x uses bits 7,0; y uses bits 10,7,5,0
  localparam logic [17:0] X_TAPS = 18'h00081;
  localparam logic [17:0] Y_TAPS = 18'h004A1;

  // Taps producing the half-period-shifted symbol z(i+2^17)
  // x: bits 4,6,15   y: bits 5,6,8..15
  localparam logic [17:0] X_ZHI  = 18'h08050;
  localparam logic [17:0] Y_ZHI  = 18'h0FF60;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    SEED = 1'b1
  } state_t;

  typedef struct packed {
    logic [17:0] x;
    logic [17:0] y;
  } xy_t;

  // One step of both recursions: shift right, feedback into bit 17
  function automatic xy_t step_xy(input logic [17:0] x, input logic [17:0] y);
    xy_t r;
    r.x = {^(x & X_TAPS), x[17:1]};
    r.y = {^(y & Y_TAPS), y[17:1]};
    return r;
  endfunction

  // {z(i+2^17), z(i)} for the state at sequence index i
  function automatic logic [1:0] z_pair(input logic [17:0] x, input logic [17:0] y);
    return {(^(x & X_ZHI)) ^ (^(y & Y_ZHI)), x[0] ^ y[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gold_lfsr_unroll.sv
`default_nettype none
// ============================================================================
//  Module   : gold_lfsr_unroll
//  Purpose  : Combinational unroll of the x/y Gold LFSR pair. Emits STEPS
//             z-pairs (lane k from the state advanced k steps) and the state
//             advanced STEPS steps.
//  Revision : 1.0  initial release
// ============================================================================
module gold_lfsr_unroll
  import gold_scrambler_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic [17:0]        i_x,
  input  logic [17:0]        i_y,
  output logic [2*STEPS-1:0] o_z,
  output logic [17:0]        o_x,
  output logic [17:0]        o_y
);

  xy_t w_chain [0:STEPS];

  assign w_chain[0] = '{x: i_x, y: i_y};

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign o_z[2*k +: 2]  = z_pair(w_chain[k].x, w_chain[k].y);
    assign w_chain[k + 1] = step_xy(w_chain[k].x, w_chain[k].y);
  end

  assign o_x = w_chain[STEPS].x;
  assign o_y = w_chain[STEPS].y;

endmodule
`default_nettype wire

// File: rtl/gold_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : gold_scrambler
//  Purpose  : CCSDS Gold-sequence scrambler generator, LANES symbols/beat,
//             runtime code number with serial seed advance, frame-synchronous
//             restart, valid/ready on both sides, one-cycle latency.
//  Revision : 1.0  initial multi-lane, runtime-code release
// ============================================================================
module gold_scrambler
  import gold_scrambler_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int FRAME_LEN = 16384
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_code_load,
  input  logic [17:0]        i_code_n,
  output logic               o_busy,
  input  logic               i_valid,
  input  logic               i_sof,
  output logic               o_ready,
  output logic               o_valid,
  output logic               o_sof,
  output logic [2*LANES-1:0] o_r,
  input  logic               i_ready
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] c_lanes = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] c_frame = CNT_W'(FRAME_LEN);

  state_t             r_state, w_state_next;
  logic [17:0]        r_x, r_y, r_x_seed, r_cnt;
  logic [CNT_W-1:0]   r_sym_cnt;

  logic               w_load, w_accept, w_restart;
  logic [17:0]        w_src_x, w_src_y, w_adv_x, w_adv_y;
  logic [2*LANES-1:0] w_z;
  logic [CNT_W-1:0]   w_cnt_base, w_cnt_sum, w_cnt_next;
  xy_t                w_seed_step;

  assign w_load    = i_code_load & (r_state == RUN);
  assign w_accept  = i_valid & o_ready;
  // A beat restarts the sequence on explicit SOF or at the natural frame wrap
  assign w_restart = i_sof | (r_sym_cnt == '0);
  assign w_src_x   = w_restart ? r_x_seed : r_x;
  assign w_src_y   = w_restart ? Y_SEED   : r_y;

  assign w_cnt_base = w_restart ? '0 : r_sym_cnt;
  assign w_cnt_sum  = w_cnt_base + c_lanes;
  assign w_cnt_next = (w_cnt_sum == c_frame) ? '0 : w_cnt_sum;

  // Only x moves during seeding; y stays at its all-ones start
  assign w_seed_step = step_xy(r_x, r_y);

  gold_lfsr_unroll #(
    .STEPS (LANES)
  ) u_unroll (
    .i_x (w_src_x),
    .i_y (w_src_y),
    .o_z (w_z),
    .o_x (w_adv_x),
    .o_y (w_adv_y)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= RUN;
    else         r_state <= w_state_next;
  end

  // Next-state: enter SEED on a non-zero code load, leave after the last step
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_load && (i_code_n != '0)) w_state_next = SEED;
      SEED:    if (r_cnt == 18'd1)             w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // FSM outputs: busy while seeding; accept only in RUN with room downstream
  always_comb begin
    o_busy  = (r_state == SEED);
    o_ready = (r_state == RUN) & ~i_code_load & (~o_valid | i_ready);
  end

  // LFSR state, seed, seed counter, frame counter and output register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_x       <= X_SEED;
      r_y       <= Y_SEED;
      r_x_seed  <= X_SEED;
      r_cnt     <= '0;
      r_sym_cnt <= '0;
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_r       <= '0;
    end else begin
      if (w_load) begin
        r_x   <= X_SEED;
        r_y   <= Y_SEED;
        r_cnt <= i_code_n;
        // Code 0 needs no advance, so its seed is the start state itself
        if (i_code_n == '0) r_x_seed <= X_SEED;
      end else if (r_state == SEED) begin
        r_x   <= w_seed_step.x;
        r_cnt <= r_cnt - 18'd1;
        if (r_cnt == 18'd1) r_x_seed <= w_seed_step.x;
      end else if (w_accept) begin
        r_x       <= w_adv_x;
        r_y       <= w_adv_y;
        r_sym_cnt <= w_cnt_next;
      end

      if (w_accept) begin
        o_valid <= 1'b1;
        o_sof   <= w_restart;
        o_r     <= w_z;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gold_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gold_scrambler
//  Purpose  : Scoreboard bench for gold_scrambler (LANES=4, FRAME_LEN=32).
//             Reference built from the x/y m-sequences as bit arrays.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gold_scrambler;

  localparam int LANES     = 4;
  localparam int FRAME_LEN = 32;
  localparam int W         = 2 * LANES;
  localparam int SEQ       = 4096;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_code_load;
  logic [17:0]   i_code_n;
  logic          o_busy;
  logic          i_valid;
  logic          i_sof;
  logic          o_ready;
  logic          o_valid;
  logic          o_sof;
  logic [W-1:0]  o_r;
  logic          i_ready;

  gold_scrambler #(
    .LANES     (LANES),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_code_load (i_code_load),
    .i_code_n    (i_code_n),
    .o_busy      (o_busy),
    .i_valid     (i_valid),
    .i_sof       (i_sof),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_r         (o_r),
    .i_ready     (i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         sof;
    logic [W-1:0] r;
  } beat_t;

  beat_t q[$];
  bit    xs[SEQ];
  bit    ys[SEQ];
  int    total = 0;
  int    bad   = 0;

  // Reference state: code n, sequence index of the running generator,
  // symbol position inside the frame, remaining busy cycles
  int    m_n    = 0;
  int    m_gen  = 0;
  int    m_pos  = 0;
  int    m_busy = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected beat from the sequence arrays: z(i) = x(i+n) ^ y(i)
  function automatic beat_t model_beat(input bit sof);
    beat_t b;
    bit    restart;
    int    base;
    restart = sof || (m_pos == 0);
    if (restart) m_gen = 0;
    b.sof = restart;
    for (int k = 0; k < LANES; k++) begin
      int i;
      int j;
      bit hi;
      i = m_gen + k;
      j = i + m_n;
      hi = xs[j+4] ^ xs[j+6] ^ xs[j+15] ^ ys[i+5] ^ ys[i+6];
      for (int t = 8; t <= 15; t++) hi = hi ^ ys[i+t];
      b.r[2*k]   = xs[j] ^ ys[i];
      b.r[2*k+1] = hi;
    end
    m_gen = m_gen + LANES;
    base  = restart ? 0 : m_pos;
    m_pos = (base + LANES) % FRAME_LEN;
    return b;
  endfunction

  function automatic void model_reset();
    m_n = 0; m_gen = 0; m_pos = 0; m_busy = 0;
    q.delete();
  endfunction

  // One clock of stimulus; entered and left at posedge+1
  task automatic cycle(input bit v, input bit sof, input bit load, input logic [17:0] n, input bit rdy);
    bit was_busy;
    bit exp_ready;
    i_valid = v; i_sof = sof; i_code_load = load; i_code_n = n; i_ready = rdy;
    @(negedge i_clk);
    #2;
    was_busy  = (m_busy > 0);
    exp_ready = !was_busy && !load && (!o_valid || rdy);
    check("o_busy", o_busy, was_busy);
    check("o_ready", o_ready, exp_ready);
    if (load && !was_busy) begin
      m_n = int'(n); m_gen = 0; m_busy = int'(n);
    end else if (was_busy) begin
      m_busy--;
    end else if (v && exp_ready) begin
      q.push_back(model_beat(sof));
    end
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: output must be present exactly when a beat is owed; compare the
  // head every cycle it is shown (so a held beat is checked for stability)
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        check("valid_vs_queue", o_valid, q.size() != 0);
        if (o_valid && q.size() != 0) begin
          check("o_sof", o_sof, q[0].sof);
          check("o_r", o_r, q[0].r);
          if (i_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    // m-sequences: bit k of the LFSR state at step i equals seq[i+k]
    xs[0] = 1'b1;
    for (int k = 1; k < 18; k++) xs[k] = 1'b0;
    for (int k = 0; k < 18; k++) ys[k] = 1'b1;
    for (int j = 0; j + 18 < SEQ; j++) begin
      xs[j+18] = xs[j+7] ^ xs[j];
      ys[j+18] = ys[j+10] ^ ys[j+7] ^ ys[j+5] ^ ys[j];
    end

    i_reset = 1'b1; i_code_load = 1'b0; i_code_n = '0;
    i_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_valid", o_valid, 0);
    check("reset_sof", o_sof, 0);
    check("reset_r", o_r, 0);
    check("reset_busy", o_busy, 0);
    i_reset = 1'b0;
    model_reset();

    // Code 0 start: first symbol pair is 00
    cycle(1, 1, 0, 0, 1);
    check("code0_valid", o_valid, 1);
    check("code0_sof", o_sof, 1);
    check("code0_lane0", o_r[1:0], 2'b00);
    for (int b = 0; b < 20; b++) cycle(1, 0, 0, 0, 1);

    // Code 1: one busy cycle, first pair 01
    cycle(0, 0, 1, 18'd1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    check("code1_lane0", o_r[1:0], 2'b01);
    for (int b = 0; b < 10; b++) cycle(1, 0, 0, 0, 1);

    // Code 5 with valid held high: five busy cycles, nothing accepted
    cycle(1, 0, 1, 18'd5, 1);
    for (int b = 0; b < 20; b++) cycle(1, 0, 0, 0, 1);

    // Mid-frame SOF restart, then auto wrap over several frames
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    for (int b = 0; b < 18; b++) cycle(1, 0, 0, 0, 1);

    // Backpressure: downstream stalls for 3 cycles with valid high
    cycle(1, 0, 0, 0, 1);
    for (int b = 0; b < 3; b++) cycle(1, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) cycle(1, 0, 0, 0, 1);

    // Load together with valid: load wins; a load during SEED is ignored
    cycle(1, 1, 1, 18'd3, 1);
    cycle(0, 0, 1, 18'd7, 1);
    for (int b = 0; b < 4; b++) cycle(1, 0, 0, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
            $urandom_range(0, 49) == 0, 18'($urandom_range(0, 40)),
            $urandom_range(0, 3) != 0);
    end

    // Reset in the middle of a long seed with an output beat still held
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 18'd1000, 0);
    for (int b = 0; b < 9; b++) cycle(0, 0, 0, 0, 0);
    i_reset = 1'b1;
    #1;
    check("midseed_busy", o_busy, 0);
    check("midseed_valid", o_valid, 0);
    check("midseed_r", o_r, 0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    for (int b = 0; b < 12; b++) cycle(1, 0, 0, 0, 1);

    // Drain with a bounded number of cycles
    for (int b = 0; b < 10 && q.size() != 0; b++) cycle(0, 0, 0, 0, 1);
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
